// File: rtl/frame_input_arbiter.sv
// Packet-granular round-robin arbiter. It merges four per-channel received-frame
// FIFOs (134-bit show-ahead data plus 64-bit metadata) onto one ingress datapath.
// Frames are forwarded whole and never interleaved. Frames longer than
// MAX_PKT_LINES are truncated with a forced tail, and the rest of the frame is
// drained without being written.
module frame_input_arbiter #(
  parameter int unsigned MAX_PKT_LINES = 128,
  parameter int unsigned CNT_W         = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [535:0] iv_pkt_data,
  input  logic [3:0]   i_pkt_data_empty,
  output logic [3:0]   ov_pkt_data_rd,
  input  logic [255:0] iv_metadata,
  input  logic [3:0]   i_metadata_fifo_empty,
  output logic [3:0]   ov_metadata_rd,
  input  logic         i_out_almost_full,
  output logic [133:0] ov_data,
  output logic         o_data_wr,
  output logic [63:0]  ov_metadata,
  output logic         o_metadata_wr,
  output logic [1:0]   ov_grant_port,
  output logic         o_abort_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRANS = 2'd1,
    DISC  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0] line_cnt, line_cnt_nxt;
  logic [1:0]       grant_nxt;
  logic [3:0]       meta_rd_nxt;
  logic [63:0]      meta_nxt;
  logic             meta_wr_nxt;
  logic [133:0]     data_nxt;
  logic             data_wr_nxt;
  logic             abort_nxt;

  logic [133:0]     ch_line [4];
  logic [63:0]      ch_meta [4];
  logic [133:0]     cur_line;
  logic             cur_tail;
  logic             pop;
  logic             arb_found;
  logic [1:0]       arb_winner;
  logic [1:0]       arb_idx;

  // Split the packed FIFO head buses into per-channel views
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      ch_line[k] = iv_pkt_data[134*k +: 134];
      ch_meta[k] = iv_metadata[64*k +: 64];
    end
  end

  // Round-robin search for the first channel with a complete frame, starting at rr_ptr
  always_comb begin
    arb_found  = 1'b0;
    arb_winner = rr_ptr;
    arb_idx    = rr_ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      arb_idx = rr_ptr + 2'(i);
      if (!arb_found && !i_metadata_fifo_empty[arb_idx]) begin
        arb_found  = 1'b1;
        arb_winner = arb_idx;
      end
    end
  end

  // Combinational pop of the granted channel's data FIFO while a frame is active
  always_comb begin
    cur_line       = ch_line[ov_grant_port];
    cur_tail       = cur_line[133];
    pop            = (state != IDLE) && !i_pkt_data_empty[ov_grant_port];
    ov_pkt_data_rd = '0;
    if (pop) begin
      ov_pkt_data_rd[ov_grant_port] = 1'b1;
    end
  end

  // Next-state and registered-output values
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    line_cnt_nxt = line_cnt;
    grant_nxt    = ov_grant_port;
    meta_rd_nxt  = '0;
    meta_nxt     = ov_metadata;
    meta_wr_nxt  = 1'b0;
    data_nxt     = ov_data;
    data_wr_nxt  = 1'b0;
    abort_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!i_out_almost_full && arb_found) begin
          grant_nxt               = arb_winner;
          meta_rd_nxt[arb_winner] = 1'b1;
          meta_nxt                = ch_meta[arb_winner];
          meta_wr_nxt             = 1'b1;
          rr_ptr_nxt              = arb_winner + 2'd1;
          line_cnt_nxt            = '0;
          state_nxt               = TRANS;
        end
      end
      TRANS: begin
        if (pop) begin
          line_cnt_nxt = line_cnt + 1'b1;
          data_nxt     = cur_line;
          data_wr_nxt  = 1'b1;
          if (cur_tail) begin
            state_nxt = IDLE;
          end else if (line_cnt == CNT_W'(MAX_PKT_LINES - 1)) begin
            // Last permitted line carries a forced tail so downstream sees a closed frame
            data_nxt[133:132] = 2'b10;
            abort_nxt         = 1'b1;
            state_nxt         = DISC;
          end
        end
      end
      DISC: begin
        if (pop && cur_tail) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      line_cnt       <= '0;
      ov_grant_port  <= '0;
      ov_metadata_rd <= '0;
      ov_metadata    <= '0;
      o_metadata_wr  <= 1'b0;
      ov_data        <= '0;
      o_data_wr      <= 1'b0;
      o_abort_pulse  <= 1'b0;
    end else begin
      state          <= state_nxt;
      rr_ptr         <= rr_ptr_nxt;
      line_cnt       <= line_cnt_nxt;
      ov_grant_port  <= grant_nxt;
      ov_metadata_rd <= meta_rd_nxt;
      ov_metadata    <= meta_nxt;
      o_metadata_wr  <= meta_wr_nxt;
      ov_data        <= data_nxt;
      o_data_wr      <= data_wr_nxt;
      o_abort_pulse  <= abort_nxt;
    end
  end

endmodule

// File: doc/frame_input_arbiter.md
Name: frame_input_arbiter

Overview:
- Packet-granular round-robin arbiter that merges the received-frame FIFOs of four interface input channels into one shared HCP ingress datapath.
- Each channel presents a show-ahead 134-bit frame-data FIFO and a 64-bit metadata FIFO. A channel's metadata entry is written only after its whole frame is in the data FIFO, so a non-empty metadata FIFO means a frame is ready.
- The block grants one channel per frame and streams that frame to the output without interleaving.
- It guards the shared path against frames that never present a tail.

Parameters:
- MAX_PKT_LINES, 128: maximum 134-bit lines forwarded per frame before a forced abort.
- CNT_W, 8: width of the line counter; must satisfy 2^CNT_W > MAX_PKT_LINES.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- iv_pkt_data  in  536  four 134-bit data FIFO heads; channel k is bits [134k+133:134k]; flags [133:132]: 01 head, 00 body, 10 tail, 11 single-line frame
- i_pkt_data_empty  in  4  per-channel data FIFO empty
- ov_pkt_data_rd  out  4  per-channel data FIFO pop; combinational
- iv_metadata  in  256  four 64-bit metadata FIFO heads; channel k is bits [64k+63:64k]
- i_metadata_fifo_empty  in  4  per-channel metadata FIFO empty
- ov_metadata_rd  out  4  per-channel metadata pop, 1-cycle pulse
- i_out_almost_full  in  1  downstream cannot accept a new frame
- ov_data  out  134  output line
- o_data_wr  out  1  ov_data valid
- ov_metadata  out  64  metadata of granted frame
- o_metadata_wr  out  1  ov_metadata valid, 1-cycle pulse
- ov_grant_port  out  2  channel currently or last granted
- o_abort_pulse  out  1  oversize-frame abort, 1-cycle pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer rr_ptr = 0; line counter 0. Reset asserted mid-frame aborts immediately, with no tail emitted and nothing popped while in reset.
- States: IDLE, TRANS, DISC.
- IDLE, arbitration:
  - Arbitration occurs when i_out_almost_full = 0 and any i_metadata_fifo_empty bit is 0.
  - Winner = first ready channel searching from rr_ptr upward, modulo 4.
  - Registered actions on that edge: ov_grant_port <= winner; ov_metadata_rd[winner] <= 1 for one cycle; ov_metadata <= winner's metadata slice; o_metadata_wr <= 1 for one cycle; rr_ptr <= winner + 1 (wraps 3 -> 0); counter <= 0; state -> TRANS.
- IDLE, no arbitration: none of the above happens and all pulses are 0.
- TRANS:
  - ov_pkt_data_rd[grant] = !i_pkt_data_empty[grant]; all other rd bits are 0.
  - On each pop, on the next edge: ov_data <= popped line, o_data_wr <= 1, counter += 1. Latency is one cycle from pop to o_data_wr.
  - Cycles with an empty data FIFO produce o_data_wr = 0, a bubble; line order is preserved.
  - A popped line with flag 10 or 11 ends the frame -> IDLE.
  - i_out_almost_full is ignored once in TRANS; frames are never stalled mid-stream by this block.
- Oversize guard:
  - Applies when a popped line is the MAX_PKT_LINES-th and its flag is 00 or 01.
  - That line is output with flags forced to 10, o_abort_pulse <= 1 for one cycle, state -> DISC.
- DISC:
  - ov_pkt_data_rd[grant] = !empty and o_data_wr = 0.
  - A popped tail (10/11) -> IDLE.
- Rules that hold in all states:
  - At most one rd bit is high in any cycle.
  - Metadata is popped exactly once per frame.
  - Arbitration is evaluated only in IDLE, so there is at least one idle cycle between frames.

Test Plan:
- Channel 2 only, rr_ptr = 0, 4-line frame (01,00,00,10), metadata 0x1122334455667788 -> one o_metadata_wr with that value; ov_grant_port = 2; 4 consecutive o_data_wr lines identical to input; rr_ptr = 3.
- All four channels each hold one 3-line frame, rr_ptr = 0 -> grants in order 0,1,2,3; 12 output lines with no interleave; ov_metadata_rd pulses once per channel; rr_ptr wraps to 0.
- i_out_almost_full = 1 with channel 1 ready -> no grant and no rd. Deassert -> grant 1. Reassert on the second line of a 5-line frame -> all 5 lines are still output.
- Channel 0 data FIFO empty for 3 cycles between lines 2 and 3 of a 6-line frame -> 3-cycle gap in o_data_wr; 6 lines output in order.
- 200-line frame, MAX_PKT_LINES = 128 -> 128 writes, the 128th with flags 10; o_abort_pulse once; the remaining 72 lines popped with no writes; next frame is granted normally.
- Single-line frame (flag 11) on channel 3 -> exactly one write, then back to IDLE. Separately, assert i_rst_n = 0 mid-frame -> all outputs 0 and rr_ptr = 0.
